// File: rtl/t08_lcd_responder.sv
// ---------------------------------------------------------------------------
// t08_lcd_responder
//   Responder side of an 8080-style parallel LCD bus. All bus inputs are
//   sampled once per clock and only the sampled copies are decoded. The
//   responder recognises a small command set (NOP, software reset, display
//   on/off, column/page address windows, pixel format, memory write and two
//   status reads), assembles 16-bit pixels from byte pairs and walks the
//   programmed address window.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   data_in[7:0]   in   bus byte from the initiator
//   wrx, rdx       in   write / read strobes (event on sampled 0->1 edge)
//   csx            in   chip select, active low (high aborts the current op)
//   dcx            in   0 = command byte, 1 = data byte
//   data_out[7:0]  out  read-back byte (0 when not driven)
//   data_oe        out  data_out valid and driven
//   cmd_valid      out  one-cycle pulse per accepted command byte
//   cmd_code[7:0]  out  code of the last accepted command
//   pixel_valid    out  one-cycle pulse per assembled pixel
//   pixel_data     out  {high byte, low byte} of the pixel
//   pixel_x/_y     out  column / row address of the pixel
//   display_on     out  display enable flag
//   pixfmt[7:0]    out  pixel format register
//   sw_reset_pulse out  one-cycle pulse on software reset command
// ---------------------------------------------------------------------------
module t08_lcd_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        wrx,
    input  logic        rdx,
    input  logic        csx,
    input  logic        dcx,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        pixel_valid,
    output logic [15:0] pixel_data,
    output logic [15:0] pixel_x,
    output logic [15:0] pixel_y,
    output logic        display_on,
    output logic [7:0]  pixfmt,
    output logic        sw_reset_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PARAM,
        ST_PIXEL,
        ST_READ
    } state_t;

    typedef enum logic [1:0] {
        PK_CASET,
        PK_PASET,
        PK_PIXFMT
    } pkind_t;

    localparam logic [15:0] SC_RST     = 16'd0;
    localparam logic [15:0] EC_RST     = 16'd239;
    localparam logic [15:0] SP_RST     = 16'd0;
    localparam logic [15:0] EP_RST     = 16'd319;
    localparam logic [7:0]  PIXFMT_RST = 8'h66;

    // Sample stage and previous-sample copies for edge detection
    logic [7:0]  r_data_s;
    logic        r_wrx_s;
    logic        r_rdx_s;
    logic        r_csx_s;
    logic        r_dcx_s;
    logic        r_wrx_p;
    logic        r_rdx_p;

    // Control state
    state_t      r_state;
    pkind_t      r_pkind;
    logic [1:0]  r_idx;
    logic [15:0] r_stg_start;
    logic [7:0]  r_stg_end_hi;
    logic [7:0]  r_hi;
    logic        r_hi_valid;
    logic        r_rd_pixfmt;

    // Configuration and address registers
    logic [15:0] r_sc;
    logic [15:0] r_ec;
    logic [15:0] r_sp;
    logic [15:0] r_ep;
    logic [15:0] r_col;
    logic [15:0] r_row;
    logic        r_display_on;
    logic [7:0]  r_pixfmt;

    // Registered outputs
    logic        r_cmd_valid;
    logic [7:0]  r_cmd_code;
    logic        r_pix_valid;
    logic [15:0] r_pix_data;
    logic [15:0] r_pix_x;
    logic [15:0] r_pix_y;
    logic        r_swrst;

    logic        w_wr_ev;
    logic        w_rd_ev;
    logic [15:0] w_col_nxt;
    logic [15:0] w_row_nxt;
    logic        w_data_oe;
    logic [7:0]  w_data_out;

    // Write has priority: a read edge in the same cycle is dropped.
    assign w_wr_ev = r_wrx_s & ~r_wrx_p & ~r_csx_s;
    assign w_rd_ev = r_rdx_s & ~r_rdx_p & ~r_csx_s & ~w_wr_ev;

    // Raster walk inside the window: wrap column to sc, then row to sp.
    always_comb begin
        w_col_nxt = r_col + 16'd1;
        w_row_nxt = r_row;
        if (r_col >= r_ec) begin
            w_col_nxt = r_sc;
            w_row_nxt = (r_row >= r_ep) ? r_sp : (r_row + 16'd1);
        end
    end

    always_comb begin
        w_data_oe  = (r_state == ST_READ) && !r_rdx_s && !r_csx_s;
        w_data_out = '0;
        if (w_data_oe) begin
            w_data_out = r_rd_pixfmt ? r_pixfmt : {5'b0, r_display_on, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_s     <= '0;
            r_wrx_s      <= 1'b1;
            r_rdx_s      <= 1'b1;
            r_csx_s      <= 1'b1;
            r_dcx_s      <= 1'b0;
            r_wrx_p      <= 1'b1;
            r_rdx_p      <= 1'b1;
            r_state      <= ST_IDLE;
            r_pkind      <= PK_CASET;
            r_idx        <= '0;
            r_stg_start  <= '0;
            r_stg_end_hi <= '0;
            r_hi         <= '0;
            r_hi_valid   <= 1'b0;
            r_rd_pixfmt  <= 1'b0;
            r_sc         <= SC_RST;
            r_ec         <= EC_RST;
            r_sp         <= SP_RST;
            r_ep         <= EP_RST;
            r_col        <= '0;
            r_row        <= '0;
            r_display_on <= 1'b0;
            r_pixfmt     <= PIXFMT_RST;
            r_cmd_valid  <= 1'b0;
            r_cmd_code   <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_data   <= '0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_swrst      <= 1'b0;
        end else begin
            r_data_s    <= data_in;
            r_wrx_s     <= wrx;
            r_rdx_s     <= rdx;
            r_csx_s     <= csx;
            r_dcx_s     <= dcx;
            r_wrx_p     <= r_wrx_s;
            r_rdx_p     <= r_rdx_s;

            r_cmd_valid <= 1'b0;
            r_pix_valid <= 1'b0;
            r_swrst     <= 1'b0;

            if (r_csx_s) begin
                // Deselect abandons any transfer but keeps configuration.
                r_state    <= ST_IDLE;
                r_idx      <= '0;
                r_hi_valid <= 1'b0;
            end else if (w_wr_ev && !r_dcx_s) begin
                r_cmd_valid <= 1'b1;
                r_cmd_code  <= r_data_s;
                r_idx       <= '0;
                r_hi_valid  <= 1'b0;
                r_state     <= ST_IDLE;
                case (r_data_s)
                    8'h01: begin
                        r_sc         <= SC_RST;
                        r_ec         <= EC_RST;
                        r_sp         <= SP_RST;
                        r_ep         <= EP_RST;
                        r_col        <= '0;
                        r_row        <= '0;
                        r_display_on <= 1'b0;
                        r_pixfmt     <= PIXFMT_RST;
                        r_pix_data   <= '0;
                        r_pix_x      <= '0;
                        r_pix_y      <= '0;
                        r_swrst      <= 1'b1;
                    end
                    8'h28: r_display_on <= 1'b0;
                    8'h29: r_display_on <= 1'b1;
                    8'h2A: begin
                        r_state <= ST_PARAM;
                        r_pkind <= PK_CASET;
                    end
                    8'h2B: begin
                        r_state <= ST_PARAM;
                        r_pkind <= PK_PASET;
                    end
                    8'h3A: begin
                        r_state <= ST_PARAM;
                        r_pkind <= PK_PIXFMT;
                    end
                    8'h2C: begin
                        r_state <= ST_PIXEL;
                        r_col   <= r_sc;
                        r_row   <= r_sp;
                    end
                    8'h0A: begin
                        r_state     <= ST_READ;
                        r_rd_pixfmt <= 1'b0;
                    end
                    8'h0C: begin
                        r_state     <= ST_READ;
                        r_rd_pixfmt <= 1'b1;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (w_wr_ev) begin
                case (r_state)
                    ST_PARAM: begin
                        if (r_pkind == PK_PIXFMT) begin
                            r_pixfmt <= r_data_s;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                            case (r_idx)
                                2'd0: r_stg_start[15:8] <= r_data_s;
                                2'd1: r_stg_start[7:0]  <= r_data_s;
                                2'd2: r_stg_end_hi      <= r_data_s;
                                default: begin
                                    // Window registers change only once all four bytes arrived.
                                    if (r_pkind == PK_CASET) begin
                                        r_sc <= r_stg_start;
                                        r_ec <= {r_stg_end_hi, r_data_s};
                                    end else begin
                                        r_sp <= r_stg_start;
                                        r_ep <= {r_stg_end_hi, r_data_s};
                                    end
                                    r_state <= ST_IDLE;
                                end
                            endcase
                        end
                    end
                    ST_PIXEL: begin
                        if (!r_hi_valid) begin
                            r_hi       <= r_data_s;
                            r_hi_valid <= 1'b1;
                        end else begin
                            r_pix_valid <= 1'b1;
                            r_pix_data  <= {r_hi, r_data_s};
                            r_pix_x     <= r_col;
                            r_pix_y     <= r_row;
                            r_col       <= w_col_nxt;
                            r_row       <= w_row_nxt;
                            r_hi_valid  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else if (w_rd_ev && (r_state == ST_READ)) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign data_out       = w_data_out;
    assign data_oe        = w_data_oe;
    assign cmd_valid      = r_cmd_valid;
    assign cmd_code       = r_cmd_code;
    assign pixel_valid    = r_pix_valid;
    assign pixel_data     = r_pix_data;
    assign pixel_x        = r_pix_x;
    assign pixel_y        = r_pix_y;
    assign display_on     = r_display_on;
    assign pixfmt         = r_pixfmt;
    assign sw_reset_pulse = r_swrst;

endmodule
